// File: rtl/core_pkg.sv
// Shared types and helpers for the fetch-side program counter.
// The state type and the offset sign extension live here so other core blocks can use them.
package core_pkg;

    localparam int PC_W_DEFAULT = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pc_state_t;

    // Returns a 32-bit value; callers size-cast it down to their PC width.
    function automatic logic [31:0] sext8(input logic [7:0] v);
        return {{24{v[7]}}, v};
    endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC adder: pc + 1, or pc + sign-extended branch offset.
// Addition is modulo 2^PC_W, so both directions wrap silently.
module pc_next_calc
    import core_pkg::*;
#(
    parameter int PC_W = PC_W_DEFAULT
) (
    input  logic [PC_W-1:0] pc_i,
    input  logic [7:0]      offset_i,
    input  logic            branch_taken_i,
    output logic [PC_W-1:0] next_pc_o
);

    logic [PC_W-1:0] step;

    assign step      = branch_taken_i ? PC_W'(sext8(offset_i)) : PC_W'(1);
    assign next_pc_o = pc_i + step;

endmodule

// File: rtl/program_counter.sv
// Program counter with IDLE/RUN/DONE run handshake and a saturating retired-instruction counter.
// All outputs come straight from registers, so every effect shows up the cycle after its edge.
module program_counter
    import core_pkg::*;
#(
    parameter int PC_W       = PC_W_DEFAULT,
    parameter int CNT_W      = 16,
    parameter int START_ADDR = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stall,
    input  logic             halt,
    input  logic             branch_en,
    input  logic             branch_cond,
    input  logic [7:0]       offset,
    output logic [PC_W-1:0]  pc,
    output logic             running,
    output logic             done,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [PC_W-1:0]  START_PC = PC_W'(START_ADDR);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    pc_state_t        state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             running_q, done_q;

    logic             branch_taken;
    logic [PC_W-1:0]  next_pc;
    logic [CNT_W-1:0] cnt_inc;

    assign branch_taken = branch_en && branch_cond;

    pc_next_calc #(
        .PC_W(PC_W)
    ) u_next (
        .pc_i           (pc_q),
        .offset_i       (offset),
        .branch_taken_i (branch_taken),
        .next_pc_o      (next_pc)
    );

    // The counter sticks at its maximum instead of wrapping back to zero.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    pc_d    = START_PC;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                // Halt retires but leaves pc on the halt instruction; it beats a taken branch.
                if (!stall) begin
                    cnt_d = cnt_inc;
                    if (halt) begin
                        state_d = DONE;
                    end else begin
                        pc_d = next_pc;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = START_PC;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pc_q      <= START_PC;
            cnt_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            running_q <= (state_d == RUN);
            done_q    <= (state_d == DONE);
        end
    end

    assign pc          = pc_q;
    assign running     = running_q;
    assign done        = done_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_program_counter.sv
// Bench for program_counter: directed vector table, a saturation sequence, then random stimulus
// checked against an arithmetic reference model.
module tb_program_counter;

    localparam int PC_W  = 10;
    localparam int CNT_W = 8;
    localparam int PC_MOD  = 1 << PC_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset, start, stall, halt, branch_en, branch_cond;
    logic [7:0]       offset;
    logic [PC_W-1:0]  pc;
    logic             running, done;
    logic [CNT_W-1:0] instr_count;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    program_counter #(
        .PC_W       (PC_W),
        .CNT_W      (CNT_W),
        .START_ADDR (0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stall       (stall),
        .halt        (halt),
        .branch_en   (branch_en),
        .branch_cond (branch_cond),
        .offset      (offset),
        .pc          (pc),
        .running     (running),
        .done        (done),
        .instr_count (instr_count)
    );

    typedef struct {
        logic       rst, st, stl, hlt, ben, bcond;
        logic [7:0] off;
        int         epc;
        logic       er, ed;
        int         ec;
    } vec_t;

    vec_t vecs[36];

    function automatic vec_t mk(logic rst, logic st, logic stl, logic hlt, logic ben, logic bcond,
                                logic [7:0] off, int epc, logic er, logic ed, int ec);
        vec_t v;
        v.rst = rst; v.st = st; v.stl = stl; v.hlt = hlt; v.ben = ben; v.bcond = bcond;
        v.off = off; v.epc = epc; v.er = er; v.ed = ed; v.ec = ec;
        return v;
    endfunction

    task automatic drive(logic rst, logic st, logic stl, logic hlt, logic ben, logic bcond,
                         logic [7:0] off);
        reset = rst; start = st; stall = stl; halt = hlt;
        branch_en = ben; branch_cond = bcond; offset = off;
    endtask

    // Apply current inputs across one rising edge, then sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, int epc, logic er, logic ed, int ec);
        tests++;
        if (pc !== PC_W'(epc) || running !== er || done !== ed || instr_count !== CNT_W'(ec)) begin
            failed++;
            $display("FAIL %s: got pc=%0d running=%0b done=%0b count=%0d, expected pc=%0d running=%0b done=%0b count=%0d",
                     name, pc, running, done, instr_count, epc, er, ed, ec);
        end
    endtask

    // Reference model state (plain integers).
    int m_mode;   // 0 idle, 1 run, 2 done
    int m_pc;
    int m_cnt;

    task automatic model_step(logic rst, logic st, logic stl, logic hlt, logic ben, logic bcond,
                              logic [7:0] off);
        int disp;
        disp = (off >= 128) ? int'(off) - 256 : int'(off);
        if (rst) begin
            m_mode = 0; m_pc = 0; m_cnt = 0;
        end else if (m_mode != 1) begin
            if (st) begin
                m_mode = 1; m_pc = 0; m_cnt = 0;
            end
        end else if (!stl) begin
            m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
            if (hlt) m_mode = 2;
            else if (ben && bcond) m_pc = ((m_pc + disp) % PC_MOD + PC_MOD) % PC_MOD;
            else m_pc = (m_pc + 1) % PC_MOD;
        end
    endtask

    initial begin
        // rst st stl hlt ben bc off     pc   r  d  cnt
        vecs[0]  = mk(1, 0, 0, 0, 0, 0, 8'h00,    0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 0, 8'h00,    0, 0, 0, 0);
        vecs[2]  = mk(0, 1, 0, 0, 0, 0, 8'h00,    0, 1, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0, 0, 0, 8'h00,    1, 1, 0, 1);
        vecs[4]  = mk(0, 0, 0, 0, 0, 0, 8'h00,    2, 1, 0, 2);
        vecs[5]  = mk(0, 0, 0, 0, 0, 0, 8'h00,    3, 1, 0, 3);
        vecs[6]  = mk(0, 0, 0, 0, 0, 0, 8'h00,    4, 1, 0, 4);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0, 8'h00,    5, 1, 0, 5);
        vecs[8]  = mk(0, 0, 0, 0, 1, 1, 8'h23,   40, 1, 0, 6);
        vecs[9]  = mk(0, 0, 0, 0, 1, 0, 8'hE2,   41, 1, 0, 7);
        vecs[10] = mk(0, 0, 0, 0, 1, 1, 8'hFF,   40, 1, 0, 8);
        vecs[11] = mk(0, 0, 0, 0, 1, 1, 8'hE2,   10, 1, 0, 9);
        vecs[12] = mk(0, 0, 0, 0, 1, 1, 8'h64,  110, 1, 0, 10);
        vecs[13] = mk(0, 0, 0, 0, 1, 1, 8'h95,    3, 1, 0, 11);
        vecs[14] = mk(0, 0, 0, 0, 1, 1, 8'hE2,  997, 1, 0, 12);
        vecs[15] = mk(0, 0, 0, 0, 1, 1, 8'h1A, 1023, 1, 0, 13);
        vecs[16] = mk(0, 0, 0, 0, 0, 0, 8'h00,    0, 1, 0, 14);
        vecs[17] = mk(0, 0, 0, 0, 1, 1, 8'h07,    7, 1, 0, 15);
        vecs[18] = mk(0, 0, 0, 0, 1, 1, 8'h00,    7, 1, 0, 16);
        vecs[19] = mk(0, 0, 0, 0, 1, 1, 8'h05,   12, 1, 0, 17);
        vecs[20] = mk(0, 1, 1, 1, 1, 1, 8'h05,   12, 1, 0, 17);
        vecs[21] = mk(0, 0, 1, 1, 1, 1, 8'h05,   12, 1, 0, 17);
        vecs[22] = mk(0, 0, 1, 1, 1, 1, 8'h05,   12, 1, 0, 17);
        vecs[23] = mk(0, 0, 0, 1, 1, 1, 8'h05,   12, 0, 1, 18);
        vecs[24] = mk(0, 0, 1, 1, 1, 1, 8'h05,   12, 0, 1, 18);
        vecs[25] = mk(0, 1, 0, 0, 0, 0, 8'h00,    0, 1, 0, 0);
        vecs[26] = mk(0, 0, 0, 0, 1, 1, 8'h14,   20, 1, 0, 1);
        vecs[27] = mk(0, 0, 0, 1, 1, 1, 8'h05,   20, 0, 1, 2);
        vecs[28] = mk(0, 1, 1, 0, 0, 0, 8'h00,    0, 1, 0, 0);
        vecs[29] = mk(0, 0, 0, 0, 1, 1, 8'h32,   50, 1, 0, 1);
        vecs[30] = mk(0, 1, 0, 0, 0, 0, 8'h00,   51, 1, 0, 2);
        vecs[31] = mk(0, 0, 0, 0, 1, 1, 8'hFF,   50, 1, 0, 3);
        vecs[32] = mk(1, 1, 0, 0, 0, 0, 8'h00,    0, 0, 0, 0);
        vecs[33] = mk(0, 1, 0, 0, 0, 0, 8'h00,    0, 1, 0, 0);
        vecs[34] = mk(0, 0, 0, 1, 0, 0, 8'h00,    0, 0, 1, 1);
        vecs[35] = mk(0, 0, 0, 1, 1, 1, 8'h09,    0, 0, 1, 1);

        drive(1, 0, 0, 0, 0, 0, 8'h00);
        #1;

        for (int i = 0; i < 36; i++) begin
            drive(vecs[i].rst, vecs[i].st, vecs[i].stl, vecs[i].hlt,
                  vecs[i].ben, vecs[i].bcond, vecs[i].off);
            step();
            check($sformatf("vec%0d", i), vecs[i].epc, vecs[i].er, vecs[i].ed, vecs[i].ec);
            $display("[TB] vec %0d: pc=%0d running=%0b done=%0b count=%0d",
                     i, pc, running, done, instr_count);
        end

        // Long straight-line run: counter must stick at its maximum while pc keeps going.
        drive(1, 0, 0, 0, 0, 0, 8'h00);
        step();
        drive(0, 1, 0, 0, 0, 0, 8'h00);
        step();
        drive(0, 0, 0, 0, 0, 0, 8'h00);
        for (int k = 1; k <= 260; k++) begin
            step();
            if (k == 254 || k == 255 || k == 256 || k == 260) begin
                check($sformatf("sat_k%0d", k), k, 1'b1, 1'b0, (k < CNT_MAX) ? k : CNT_MAX);
                $display("[TB] sat step %0d: pc=%0d count=%0d", k, pc, instr_count);
            end
        end

        // Random stimulus against the reference model, starting from a known reset.
        drive(1, 0, 0, 0, 0, 0, 8'h00);
        model_step(1, 0, 0, 0, 0, 0, 8'h00);
        step();
        check("rand_reset", m_pc, m_mode == 1, m_mode == 2, m_cnt);
        for (int n = 0; n < 3000; n++) begin
            logic       r_rst, r_st, r_stl, r_hlt, r_ben, r_bc;
            logic [7:0] r_off;
            r_rst = ($urandom_range(0, 99) == 0);
            r_st  = ($urandom_range(0, 7) == 0);
            r_stl = ($urandom_range(0, 3) == 0);
            r_hlt = ($urandom_range(0, 39) == 0);
            r_ben = $urandom_range(0, 1) == 1;
            r_bc  = $urandom_range(0, 1) == 1;
            r_off = 8'($urandom);
            drive(r_rst, r_st, r_stl, r_hlt, r_ben, r_bc, r_off);
            model_step(r_rst, r_st, r_stl, r_hlt, r_ben, r_bc, r_off);
            step();
            check($sformatf("rand%0d", n), m_pc, m_mode == 1, m_mode == 2, m_cnt);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
